// File: rtl/seq1010_pkg.sv
// rtl/seq1010_pkg.sv - detector state encoding and next-state function for the shared 1010 detector
package seq1010_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_1    = 3'd1,
      S_10   = 3'd2,
      S_101  = 3'd3,
      S_DET  = 3'd4
   } det_state_t;

   localparam logic [3:0] PATTERN = 4'b1010;

   // Unused encodings fall into the default arm and behave exactly like S_IDLE.
   function automatic det_state_t det_next(input det_state_t s, input logic b);
      det_state_t n;
      case (s)
         S_IDLE:  n = b ? S_1   : S_IDLE;
         S_1:     n = b ? S_1   : S_10;
         S_10:    n = b ? S_101 : S_IDLE;
         S_101:   n = b ? S_1   : S_DET;
         S_DET:   n = b ? S_101 : S_IDLE;
         default: n = b ? S_1   : S_IDLE;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/seq1010_share_ctrl_rr_arbiter.sv
// rtl/seq1010_share_ctrl_rr_arbiter.sv - round-robin one-hot arbiter searching upward from ptr with wrap
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx
);

   always_comb begin
      int   v_idx;
      logic v_found;
      v_idx   = 0;
      v_found = 1'b0;
      gnt     = '0;
      gnt_idx = '0;
      for (int k = 0; k < N; k++) begin
         v_idx = int'(ptr) + k;
         if (v_idx >= N) v_idx = v_idx - N;
         if (!v_found && req[v_idx]) begin
            v_found      = 1'b1;
            gnt[v_idx]   = 1'b1;
            gnt_idx      = IW'(v_idx);
         end
      end
   end

endmodule

// File: rtl/seq1010_share_ctrl.sv
// rtl/seq1010_share_ctrl.sv - one 1010 detector time-shared across NCH serial channels
// Per-channel detector state and saturating match counters are saved/restored around each grant.
module seq1010_share_ctrl
   import seq1010_pkg::*;
#(
   parameter int   NCH   = 4,
   parameter int   CNT_W = 8,
   localparam int  CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [NCH-1:0]   ch_valid,
   input  logic [NCH-1:0]   ch_bit,
   output logic [NCH-1:0]   ch_ready,
   input  logic [NCH-1:0]   ch_clear,
   output logic             det_valid,
   output logic [CH_W-1:0]  det_ch,
   input  logic [CH_W-1:0]  cnt_sel,
   output logic [CNT_W-1:0] cnt_out,
   output logic             busy
);

   logic [2:0]       r_st  [NCH];
   logic [CNT_W-1:0] r_cnt [NCH];
   logic [CH_W-1:0]  r_rr_ptr;
   logic             r_det_valid;
   logic [CH_W-1:0]  r_det_ch;
   logic             r_busy;

   logic [NCH-1:0]   w_elig;
   logic [NCH-1:0]   w_gnt;
   logic [CH_W-1:0]  w_gnt_idx;
   logic             w_accept;
   det_state_t       w_next;
   logic [CH_W-1:0]  w_ptr_next;

   // A channel being cleared sits out arbitration for that cycle.
   assign w_elig = ch_valid & ~ch_clear & {NCH{en}};

   rr_arbiter #(
      .N  (NCH),
      .IW (CH_W)
   ) u_arb (
      .req     (w_elig),
      .ptr     (r_rr_ptr),
      .gnt     (w_gnt),
      .gnt_idx (w_gnt_idx)
   );

   assign ch_ready   = w_gnt;
   assign w_accept   = |w_gnt;
   assign w_next     = det_next(det_state_t'(r_st[w_gnt_idx]), ch_bit[w_gnt_idx]);
   assign w_ptr_next = (w_gnt_idx == CH_W'(NCH - 1)) ? '0 : w_gnt_idx + CH_W'(1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NCH; i++) begin
            r_st[i]  <= S_IDLE;
            r_cnt[i] <= '0;
         end
         r_rr_ptr    <= '0;
         r_det_valid <= 1'b0;
         r_det_ch    <= '0;
         r_busy      <= 1'b0;
      end else begin
         r_det_valid <= 1'b0;
         r_busy      <= w_accept;
         if (w_accept) begin
            r_st[w_gnt_idx] <= w_next;
            r_rr_ptr        <= w_ptr_next;
            if (w_next == S_DET) begin
               r_det_valid <= 1'b1;
               r_det_ch    <= w_gnt_idx;
               if (r_cnt[w_gnt_idx] != '1)
                  r_cnt[w_gnt_idx] <= r_cnt[w_gnt_idx] + CNT_W'(1);
            end
         end
         for (int i = 0; i < NCH; i++) begin
            if (ch_clear[i]) begin
               r_st[i]  <= S_IDLE;
               r_cnt[i] <= '0;
            end
         end
      end
   end

   assign det_valid = r_det_valid;
   assign det_ch    = r_det_ch;
   assign busy      = r_busy;
   assign cnt_out   = r_cnt[cnt_sel];

endmodule

// File: tb/tb_seq1010_share_ctrl.sv
// tb/tb_seq1010_share_ctrl.sv - directed self-checking bench for seq1010_share_ctrl
module tb_seq1010_share_ctrl;
   import seq1010_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic [3:0] ch_valid, ch_bit, ch_clear, ch_ready;
   logic       det_valid, busy;
   logic [1:0] det_ch, cnt_sel;
   logic [7:0] cnt_out;
   logic [3:0] s_ready;
   logic       s_det_valid, s_busy;
   logic [1:0] s_det_ch, s_cnt_out;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   seq1010_share_ctrl #(.NCH(4), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .en(en), .ch_valid(ch_valid), .ch_bit(ch_bit),
      .ch_ready(ch_ready), .ch_clear(ch_clear), .det_valid(det_valid), .det_ch(det_ch),
      .cnt_sel(cnt_sel), .cnt_out(cnt_out), .busy(busy));

   seq1010_share_ctrl #(.NCH(4), .CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .en(en), .ch_valid(ch_valid), .ch_bit(ch_bit),
      .ch_ready(s_ready), .ch_clear(ch_clear), .det_valid(s_det_valid), .det_ch(s_det_ch),
      .cnt_sel(cnt_sel), .cnt_out(s_cnt_out), .busy(s_busy));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_all();
      ch_valid = 4'b0000;
      ch_clear = 4'b1111;
      step();
      ch_clear = 4'b0000;
   endtask

   task automatic test_reset();
      reset = 1'b0; en = 1'b1; ch_valid = '0; ch_bit = '0; ch_clear = '0; cnt_sel = '0;
      step(); step();
      total++; if (det_valid !== 1'b0) begin bad++; $display("FAIL reset_det_valid got=%b exp=0", det_valid); end
      total++; if (det_ch !== 2'd0) begin bad++; $display("FAIL reset_det_ch got=%0d exp=0", det_ch); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (cnt_out !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", cnt_out); end
      reset = 1'b1;
      ch_valid = 4'b1100;
      #1;
      total++; if (ch_ready !== 4'b0100) begin bad++; $display("FAIL reset_first_grant got=%b exp=0100", ch_ready); end
      ch_valid = 4'b0000;
   endtask

   task automatic test_all_channels();
      logic [3:0] e_rdy;
      logic       b;
      for (int c = 0; c < 16; c++) begin
         b = PATTERN[3 - c / 4];
         ch_valid = 4'b1111;
         ch_bit   = {4{b}};
         e_rdy    = 4'b0001 << (c % 4);
         #1;
         total++; if (ch_ready !== e_rdy) begin bad++; $display("FAIL all_ready[%0d] got=%b exp=%b", c, ch_ready, e_rdy); end
         step();
         total++; if (det_valid !== (c >= 12)) begin bad++; $display("FAIL all_det_valid[%0d] got=%b exp=%b", c, det_valid, (c >= 12)); end
         if (c >= 12) begin
            total++; if (det_ch !== 2'(c % 4)) begin bad++; $display("FAIL all_det_ch[%0d] got=%0d exp=%0d", c, det_ch, c % 4); end
         end
      end
      ch_valid = '0;
      for (int i = 0; i < 4; i++) begin
         cnt_sel = 2'(i);
         #1;
         total++; if (cnt_out !== 8'd1) begin bad++; $display("FAIL all_cnt[%0d] got=%0d exp=1", i, cnt_out); end
      end
   endtask

   task automatic test_single();
      logic [5:0] bits;
      bits = 6'b101010;
      for (int i = 0; i < 6; i++) begin
         ch_valid = 4'b0001;
         ch_bit   = {3'b000, bits[5 - i]};
         #1;
         total++; if (ch_ready !== 4'b0001) begin bad++; $display("FAIL single_ready[%0d] got=%b exp=0001", i, ch_ready); end
         step();
         total++; if (det_valid !== (i == 3 || i == 5)) begin bad++; $display("FAIL single_det[%0d] got=%b exp=%b", i, det_valid, (i == 3 || i == 5)); end
         total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy[%0d] got=%b exp=1", i, busy); end
      end
      total++; if (det_ch !== 2'd0) begin bad++; $display("FAIL single_det_ch got=%0d exp=0", det_ch); end
      ch_valid = '0;
      step();
      total++; if (det_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_idle got=%b%b exp=00", det_valid, busy); end
      cnt_sel = 2'd0;
      #1;
      total++; if (cnt_out !== 8'd2) begin bad++; $display("FAIL single_cnt got=%0d exp=2", cnt_out); end
   endtask

   task automatic test_clear();
      logic [2:0] pre;
      logic [3:0] post;
      pre = 3'b101;
      for (int i = 0; i < 3; i++) begin
         ch_valid = 4'b0100; ch_bit = {1'b0, pre[2 - i], 2'b00};
         step();
      end
      ch_valid = 4'b0101; ch_clear = 4'b0100; ch_bit = 4'b0001;
      #1;
      total++; if (ch_ready !== 4'b0001) begin bad++; $display("FAIL clear_ready got=%b exp=0001", ch_ready); end
      step();
      ch_clear = '0;
      total++; if (busy !== 1'b1 || det_valid !== 1'b0) begin bad++; $display("FAIL clear_other_accept got=%b%b exp=10", busy, det_valid); end
      cnt_sel = 2'd2;
      #1;
      total++; if (cnt_out !== 8'd0) begin bad++; $display("FAIL clear_cnt got=%0d exp=0", cnt_out); end
      ch_valid = 4'b0100; ch_bit = 4'b0000;
      #1;
      total++; if (ch_ready !== 4'b0100) begin bad++; $display("FAIL clear_ready2 got=%b exp=0100", ch_ready); end
      step();
      total++; if (det_valid !== 1'b0) begin bad++; $display("FAIL clear_no_det got=%b exp=0", det_valid); end
      post = PATTERN;
      for (int i = 0; i < 4; i++) begin
         ch_valid = 4'b0100; ch_bit = {1'b0, post[3 - i], 2'b00};
         step();
         total++; if (det_valid !== (i == 3)) begin bad++; $display("FAIL clear_redet[%0d] got=%b exp=%b", i, det_valid, (i == 3)); end
      end
      total++; if (det_ch !== 2'd2 || cnt_out !== 8'd1) begin bad++; $display("FAIL clear_final got=ch%0d cnt%0d exp=ch2 cnt1", det_ch, cnt_out); end
      ch_valid = '0;
   endtask

   task automatic test_enable();
      logic [2:0] pre;
      pre = 3'b101;
      for (int i = 0; i < 3; i++) begin
         ch_valid = 4'b0010; ch_bit = {2'b00, pre[2 - i], 1'b0};
         step();
      end
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ch_valid = 4'b1111; ch_bit = 4'b0000;
         #1;
         total++; if (ch_ready !== 4'b0000) begin bad++; $display("FAIL en_ready[%0d] got=%b exp=0000", i, ch_ready); end
         step();
         total++; if (busy !== 1'b0 || det_valid !== 1'b0) begin bad++; $display("FAIL en_hold[%0d] got=%b%b exp=00", i, busy, det_valid); end
      end
      en = 1'b1;
      #1;
      total++; if (ch_ready !== 4'b0100) begin bad++; $display("FAIL en_resume got=%b exp=0100", ch_ready); end
      step();
      ch_valid = 4'b0010; ch_bit = 4'b0000;
      #1;
      total++; if (ch_ready !== 4'b0010) begin bad++; $display("FAIL en_ch1_ready got=%b exp=0010", ch_ready); end
      step();
      total++; if (det_valid !== 1'b1 || det_ch !== 2'd1) begin bad++; $display("FAIL en_state_kept got=%b ch%0d exp=1 ch1", det_valid, det_ch); end
      ch_valid = '0;
   endtask

   task automatic test_reset_mid();
      logic [2:0] pre;
      logic [3:0] post;
      pre = 3'b101;
      cnt_sel = 2'd1;
      for (int i = 0; i < 3; i++) begin
         ch_valid = 4'b1000; ch_bit = {pre[2 - i], 3'b000};
         step();
      end
      ch_valid = '0;
      reset = 1'b0;
      #1;
      total++; if (busy !== 1'b0 || det_ch !== 2'd0 || det_valid !== 1'b0) begin bad++; $display("FAIL rstmid_outs got=%b%0d%b exp=000", busy, det_ch, det_valid); end
      total++; if (cnt_out !== 8'd0) begin bad++; $display("FAIL rstmid_cnt got=%0d exp=0", cnt_out); end
      step();
      reset = 1'b1;
      ch_valid = 4'b1000; ch_bit = 4'b0000;
      step();
      total++; if (det_valid !== 1'b0) begin bad++; $display("FAIL rstmid_no_det got=%b exp=0", det_valid); end
      post = PATTERN;
      for (int i = 0; i < 4; i++) begin
         ch_valid = 4'b1000; ch_bit = {post[3 - i], 3'b000};
         step();
         total++; if (det_valid !== (i == 3)) begin bad++; $display("FAIL rstmid_det[%0d] got=%b exp=%b", i, det_valid, (i == 3)); end
      end
      total++; if (det_ch !== 2'd3) begin bad++; $display("FAIL rstmid_det_ch got=%0d exp=3", det_ch); end
      ch_valid = '0;
   endtask

   task automatic test_saturation();
      logic [11:0] bits;
      logic        e;
      bits = 12'b101010101010;
      for (int i = 0; i < 12; i++) begin
         ch_valid = 4'b0010; ch_bit = {2'b00, bits[11 - i], 1'b0};
         step();
         e = (i >= 3) && (i % 2 == 1);
         total++; if (s_det_valid !== e) begin bad++; $display("FAIL sat_det[%0d] got=%b exp=%b", i, s_det_valid, e); end
      end
      ch_valid = '0;
      cnt_sel = 2'd1;
      #1;
      total++; if (s_cnt_out !== 2'd3) begin bad++; $display("FAIL sat_cnt got=%0d exp=3", s_cnt_out); end
      total++; if (cnt_out !== 8'd5) begin bad++; $display("FAIL sat_wide_cnt got=%0d exp=5", cnt_out); end
   endtask

   initial begin
      test_reset();
      test_all_channels();
      clear_all();
      test_single();
      clear_all();
      test_clear();
      clear_all();
      test_enable();
      test_reset_mid();
      clear_all();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seq1010_share_ctrl.md
Name: seq1010_share_ctrl

Overview:
- Time-multiplexes one overlapping "1010" Moore detector across NCH independent serial bit channels.
- Round-robin arbitration picks one channel bit per cycle. The controller saves and restores each channel's detector state, and keeps a saturating match counter per channel.
- Sits between the serial front-ends and the event/status logic. It replaces NCH copies of the detector FSM.

Parameters:
- NCH, 4, number of serial channels (2..16).
- CH_W, $clog2(NCH) (min 1), channel index width (derived, not overridden).
- CNT_W, 8, width of per-channel match counters.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  global enable; when low, no grants are issued and all state holds.
- ch_valid  in  NCH  per-channel bit-valid request.
- ch_bit  in  NCH  per-channel serial data bit.
- ch_ready  out  NCH  one-hot grant (combinational). Bit accepted when ch_valid[i] & ch_ready[i].
- ch_clear  in  NCH  per-channel synchronous clear of detector state and counter.
- det_valid  out  1  registered one-cycle pulse: a channel's detector reached DETECT.
- det_ch  out  CH_W  channel index for det_valid; holds its last value otherwise.
- cnt_sel  in  CH_W  counter read select.
- cnt_out  out  CNT_W  match counter of channel cnt_sel (combinational read).
- busy  out  1  registered; high the cycle after any acceptance.

Behaviour:
- Detector states (3-bit encoding, package enum): S_IDLE=0, S_1=1, S_10=2, S_101=3, S_DET=4. Encodings 5..7 are illegal and map to S_IDLE.
- Transitions (bit=0 / bit=1):
  - IDLE: IDLE / 1
  - 1: 10 / 1
  - 10: IDLE / 101
  - 101: DET / 1
  - DET: IDLE / 101
- Overlap is supported: in "1010" followed by "10", the second "10" completes a second match.
- Storage: st[i] (3 bits), cnt[i] (CNT_W), rr_ptr (CH_W).
- Arbitration:
  - eligible[i] = ch_valid[i] & ~ch_clear[i] & en.
  - Grant goes to the first eligible channel searching from rr_ptr upward, with wrap.
  - At most one ch_ready bit is set. ch_ready is all-zero if nothing is eligible.
  - ch_ready may depend combinationally on ch_valid. Requesters must not make ch_valid depend on ch_ready.
- On acceptance of channel g at edge t:
  - st[g] <= next(st[g], ch_bit[g]).
  - rr_ptr <= (g+1) mod NCH.
  - Other channels hold.
- Detection: if the new st[g] == S_DET:
  - det_valid=1 and det_ch=g during cycle t+1 (one-cycle latency).
  - cnt[g] increments, saturating at all-ones.
- det_valid is low in every cycle that does not follow a DET-producing acceptance.
- rr_ptr does not move when there is no acceptance.
- ch_clear[i]:
  - Next edge sets st[i]=S_IDLE and cnt[i]=0.
  - Channel i is masked from the grant that cycle.
  - A clear on channel j does not affect other channels' acceptances.
- en low: no grants and rr_ptr holds. ch_clear still takes effect.
- Back-to-back grants to the same channel are allowed when it is the only requester.
- Reset (asynchronous, any time, including mid-stream): all st=S_IDLE, cnt=0, rr_ptr=0, det_valid=0, det_ch=0, busy=0. First grant after release goes to the lowest eligible index.
- Illegal stored state (5..7) is treated as S_IDLE for next-state computation.

Decomposition:
- Package seq1010_pkg:
  - state enum det_state_t with the encodings above.
  - Constant PATTERN=4'b1010.
  - Function det_next(det_state_t, bit) returning the next state.
- Sub-module rr_arbiter (param N): req[N], ptr → one-hot gnt[N] and gnt_idx.
- The top level holds the state and counter arrays and the output registers.

Test Plan:
- Single channel 0: stream 1,0,1,0,1,0 with other channels idle → det_valid pulses with det_ch=0 one cycle after the 4th and 6th accepted bits; cnt_out(sel=0)=2.
- All 4 channels valid every cycle → grants cycle 0,1,2,3,0,…; each channel is accepted once per 4 cycles. Feeding 1010 per channel gives det_ch sequence 0,1,2,3 on consecutive cycles; each counter = 1.
- Channel 2 streams 1,0,1 then ch_clear[2] with ch_valid[2]=1 → no grant that cycle; st[2]=IDLE, cnt[2]=0. A following 0 gives no detect; a later full 1010 gives a detect.
- Saturation with CNT_W=2: five matches on channel 1 → cnt_out=3 and det_valid still pulses on every match.
- en=0 for 3 cycles while valid is held → ch_ready=0 and no state change. On en=1, the grant resumes at the held rr_ptr.
- Reset asserted mid-pattern (after 1,0,1 on channel 3) → outputs zero immediately. After release, a single 0 gives no detect; 1010 gives a detect one cycle after the final bit.
